// File: rtl/window_gen.sv
// window_gen: paced pseudo-random window position generator.
//   iClk        clock
//   iRst        synchronous active-low reset
//   iFrameTick  one-cycle pulse per frame
//   iEnable     run request; low returns to idle without pushing
//   iPause      freezes the frame counter
//   oShift      one-cycle push strobe for the downstream position register
//   oValue      new window position, valid with oShift and held afterwards
//   oCount      windows pushed so far, saturating at P_NUM
//   oFull       high once oCount reaches P_NUM
module window_gen #(
  parameter int V_TOT = 525,
  parameter int P_NUM = 4,
  parameter int GAP = 120,
  parameter int MARGIN = 40,
  parameter int PERIOD = 60,
  parameter logic [15:0] SEED = 16'hACE1,
  localparam int V_SIZE = $clog2(V_TOT),
  localparam int C_SIZE = $clog2(P_NUM + 1)
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iFrameTick,
  input  logic              iEnable,
  input  logic              iPause,
  output logic              oShift,
  output logic [V_SIZE-1:0] oValue,
  output logic [C_SIZE-1:0] oCount,
  output logic              oFull
);
  localparam int RANGE = V_TOT - GAP - 2 * MARGIN;
  localparam logic [V_SIZE-1:0] RANGE_V = V_SIZE'(RANGE);
  localparam logic [V_SIZE-1:0] MARGIN_V = V_SIZE'(MARGIN);
  localparam logic [C_SIZE-1:0] FULL_V = C_SIZE'(P_NUM);
  localparam logic [7:0] LAST_V = 8'(PERIOD - 1);
  // an all-zero seed would lock the LFSR
  localparam logic [15:0] SEED_V = (SEED == 16'h0) ? 16'h0001 : SEED;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WAIT = 3'd1;
  localparam logic [2:0] GEN  = 3'd2;
  localparam logic [2:0] FOLD = 3'd3;
  localparam logic [2:0] EMIT = 3'd4;
  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [15:0] lfsr_q, lfsr_d, lfsr_nx;
  logic [V_SIZE-1:0] raw_q, raw_d, value_q, value_d;
  logic [C_SIZE-1:0] count_q, count_d;
  logic shift_q, shift_d, full_q;
  assign lfsr_nx = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    lfsr_d = lfsr_q;
    raw_d = raw_q;
    value_d = value_q;
    count_d = count_q;
    shift_d = 1'b0;
    if (state_q != IDLE && !iEnable) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: begin
          state_d = iEnable ? WAIT : IDLE;
          cnt_d = iEnable ? 8'd0 : cnt_q;
        end
        WAIT: if (iFrameTick && !iPause) begin
          cnt_d = (cnt_q == LAST_V) ? 8'd0 : cnt_q + 8'd1;
          state_d = (cnt_q == LAST_V) ? GEN : WAIT;
        end
        GEN: begin
          lfsr_d = lfsr_nx;
          raw_d = lfsr_nx[V_SIZE-1:0];
          state_d = FOLD;
        end
        // modulo by repeated subtraction, one step per cycle
        FOLD: begin
          raw_d = (raw_q >= RANGE_V) ? raw_q - RANGE_V : raw_q;
          value_d = (raw_q >= RANGE_V) ? value_q : MARGIN_V + raw_q;
          state_d = (raw_q >= RANGE_V) ? FOLD : EMIT;
        end
        EMIT: begin
          shift_d = 1'b1;
          count_d = (count_q == FULL_V) ? count_q : count_q + 1'b1;
          state_d = WAIT;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      state_q <= IDLE;
      cnt_q <= 8'd0;
      lfsr_q <= SEED_V;
      raw_q <= '0;
      value_q <= '0;
      count_q <= '0;
      shift_q <= 1'b0;
      full_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      lfsr_q <= lfsr_d;
      raw_q <= raw_d;
      value_q <= value_d;
      count_q <= count_d;
      shift_q <= shift_d;
      full_q <= (count_d == FULL_V);
    end
  end
  assign oShift = shift_q;
  assign oValue = value_q;
  assign oCount = count_q;
  assign oFull = full_q;
endmodule

// File: tb/tb_window_gen.sv
// tb_window_gen: directed and random checks for window_gen.
module tb_window_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0, tick = 1'b0, en = 1'b0, pause = 1'b0;
  logic shift, full;
  logic [9:0] value;
  logic [2:0] count;
  logic rst_r = 1'b0, tick_r = 1'b0, en_r = 1'b0, pause_r = 1'b0;
  logic shift_r, full_r;
  logic [9:0] value_r;
  logic [2:0] count_r;
  int n_cmp = 0;
  int n_err = 0;
  window_gen dut (
    .iClk(clk), .iRst(rst_n), .iFrameTick(tick), .iEnable(en), .iPause(pause),
    .oShift(shift), .oValue(value), .oCount(count), .oFull(full)
  );
  window_gen #(.PERIOD(1)) dut_r (
    .iClk(clk), .iRst(rst_r), .iFrameTick(tick_r), .iEnable(en_r), .iPause(pause_r),
    .oShift(shift_r), .oValue(value_r), .oCount(count_r), .oFull(full_r)
  );
  typedef struct {
    int ticks;
    int exp_value;
    int exp_count;
    int exp_full;
    int exp_lat;
  } vec_t;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    tick = 1'b0;
    pause = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic ticks(input int n, output int seen);
    seen = 0;
    repeat (n) begin
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        seen += int'(shift);
        tick = (c == 0);
      end
    end
  endtask
  task automatic last_tick(output int lat);
    @(negedge clk);
    tick = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      tick = 1'b0;
      if (shift === 1'b1) lat = k - 1;
    end
  endtask
  task automatic tick_to_fold();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
  endtask
  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction
  initial begin
    vec_t v[5];
    int seen, lat, shifts, cyc;
    logic prev;
    logic [15:0] lfsr_m;
    v[0] = '{60, 166, 1, 0, 4};
    v[1] = '{60, 293, 2, 0, 5};
    v[2] = '{60, 173, 3, 0, 5};
    v[3] = '{60, 257, 4, 1, 4};
    v[4] = '{60, 100, 4, 1, 3};
    do_reset();
    @(negedge clk);
    check("rst_shift", 32'(shift), 0);
    check("rst_value", 32'(value), 0);
    check("rst_count", 32'(count), 0);
    check("rst_full", 32'(full), 0);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ticks(v[i].ticks - 1, seen);
      check($sformatf("v%0d_early", i), seen, 0);
      last_tick(lat);
      check($sformatf("v%0d_lat", i), lat, v[i].exp_lat);
      check($sformatf("v%0d_value", i), 32'(value), v[i].exp_value);
      check($sformatf("v%0d_count", i), 32'(count), v[i].exp_count);
      check($sformatf("v%0d_full", i), 32'(full), v[i].exp_full);
      @(negedge clk);
      check($sformatf("v%0d_pulse", i), 32'(shift), 0);
    end
    // enable dropped while folding the second value
    do_reset();
    en = 1'b1;
    ticks(59, seen);
    last_tick(lat);
    check("drop_first", 32'(value), 166);
    ticks(59, seen);
    tick_to_fold();
    en = 1'b0;
    ticks(5, seen);
    check("drop_noshift", seen, 0);
    check("drop_count", 32'(count), 1);
    check("drop_value", 32'(value), 166);
    en = 1'b1;
    ticks(59, seen);
    check("reen_early", seen, 0);
    last_tick(lat);
    check("reen_lat", lat, 5);
    check("reen_value", 32'(value), 173);
    check("reen_count", 32'(count), 2);
    // reset while folding
    ticks(59, seen);
    tick_to_fold();
    rst_n = 1'b0;
    @(negedge clk);
    check("rstf_shift", 32'(shift), 0);
    check("rstf_value", 32'(value), 0);
    check("rstf_count", 32'(count), 0);
    check("rstf_full", 32'(full), 0);
    @(negedge clk);
    check("rstf_shift2", 32'(shift), 0);
    rst_n = 1'b1;
    ticks(59, seen);
    check("rstf_early", seen, 0);
    last_tick(lat);
    check("rstf_lat", lat, 4);
    check("rstf_again", 32'(value), 166);
    check("rstf_cnt1", 32'(count), 1);
    // pause for 30 ticks mid-period
    do_reset();
    en = 1'b1;
    ticks(20, seen);
    check("pause_pre", seen, 0);
    pause = 1'b1;
    ticks(30, seen);
    check("pause_hold", seen, 0);
    pause = 1'b0;
    ticks(39, seen);
    check("pause_post", seen, 0);
    last_tick(lat);
    check("pause_lat", lat, 4);
    check("pause_value", 32'(value), 166);
    en = 1'b0;
    // random run on a PERIOD=1 instance
    @(negedge clk);
    rst_r = 1'b1;
    en_r = 1'b1;
    lfsr_m = 16'hACE1;
    shifts = 0;
    cyc = 0;
    prev = 1'b0;
    while (cyc < 75000 && shifts < 10000) begin
      @(negedge clk);
      cyc++;
      if (shift_r === 1'b1) begin
        check("rand_consec", 32'(prev), 0);
        lfsr_m = step(lfsr_m);
        check("rand_value", 32'(value_r), 40 + (int'(lfsr_m[9:0]) % 325));
        check("rand_range", 32'(value_r >= 10'd40 && value_r <= 10'd364), 1);
        shifts++;
      end
      prev = shift_r;
      tick_r = ($urandom_range(0, 7) != 0);
      pause_r = ($urandom_range(0, 15) == 0);
    end
    check("rand_shifts", shifts, 10000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
